// File: rtl/fp8_pkg.sv
// Shared definitions for the FP8 (E4M3) multiply-accumulate datapath.
// Contents: format constants, NaN encoding, decoded-operand bundle type and
// a NaN test helper. The NaN encoding is only acted on when FP8_MAC_NAN_EN
// is defined.
package fp8_pkg;

    localparam int E4M3_BIAS   = 7;
    localparam int ACC_LSB_EXP = -18;   // accumulator LSB weight is 2^ACC_LSB_EXP
    localparam int SHIFT_W     = 5;
    localparam int PROD_W      = 8;

    localparam logic [3:0] NAN_EXP  = 4'hF;
    localparam logic [2:0] NAN_MANT = 3'b111;

    // Decoded operand: mant[3] is the hidden bit (0 for denormals)
    typedef struct packed {
        logic       sign;
        logic [3:0] exp;
        logic [3:0] mant;
    } fp8_dec_t;

    function automatic logic is_nan(fp8_dec_t op);
        return (op.exp == NAN_EXP) && (op.mant[2:0] == NAN_MANT);
    endfunction

endpackage

// File: rtl/fp8_product_align.sv
// Stages S1 and S2 of the FP8 MAC processing element.
// S1 registers the exact 8-bit mantissa product, the 5-bit alignment shift
// and the product sign; S2 registers the aligned, signed ACC_W-bit term.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/first/last   beat qualifiers from the decoder
//   a, b                  decoded operands
//   t_valid/t_first/t_last qualifiers aligned with t_term (S2)
//   t_term                signed two's-complement term, LSB weight 2^-18
//   t_nan                 (FP8_MAC_NAN_EN only) term came from a NaN operand
module fp8_product_align
    import fp8_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             first,
    input  logic             last,
    input  fp8_dec_t         a,
    input  fp8_dec_t         b,
    output logic             t_valid,
    output logic             t_first,
    output logic             t_last,
    output logic [ACC_W-1:0] t_term
`ifdef FP8_MAC_NAN_EN
    ,
    output logic             t_nan
`endif
);

    logic [3:0]         ea_eff;
    logic [3:0]         eb_eff;
    logic [PROD_W-1:0]  p_c;
    logic [SHIFT_W-1:0] s_c;

    logic               s1_valid;
    logic               s1_first;
    logic               s1_last;
    logic               s1_sign;
    logic [PROD_W-1:0]  s1_p;
    logic [SHIFT_W-1:0] s1_s;
    logic [ACC_W-1:0]   mag;

`ifdef FP8_MAC_NAN_EN
    logic               nan_c;
    logic               s1_nan;
`endif

    always_comb begin
        ea_eff = (a.exp == 4'd0) ? 4'd1 : a.exp;
        eb_eff = (b.exp == 4'd0) ? 4'd1 : b.exp;
        p_c    = {4'd0, a.mant} * {4'd0, b.mant};
        // e_eff >= 1 on both sides, so the sum minus 2 never underflows
        s_c    = {1'b0, ea_eff} + {1'b0, eb_eff} - 5'd2;
`ifdef FP8_MAC_NAN_EN
        nan_c  = is_nan(a) | is_nan(b);
        if (nan_c) begin
            p_c = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sign  <= 1'b0;
            s1_p     <= '0;
            s1_s     <= '0;
`ifdef FP8_MAC_NAN_EN
            s1_nan   <= 1'b0;
`endif
        end else begin
            s1_valid <= in_valid;
            s1_first <= first;
            s1_last  <= last;
            s1_sign  <= a.sign ^ b.sign;
            s1_p     <= p_c;
            s1_s     <= s_c;
`ifdef FP8_MAC_NAN_EN
            s1_nan   <= nan_c;
`endif
        end
    end

    // Largest magnitude is 225 << 28 (< 2^36), which fits any legal ACC_W
    assign mag = {{(ACC_W-PROD_W){1'b0}}, s1_p} << s1_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid <= 1'b0;
            t_first <= 1'b0;
            t_last  <= 1'b0;
            t_term  <= '0;
`ifdef FP8_MAC_NAN_EN
            t_nan   <= 1'b0;
`endif
        end else begin
            t_valid <= s1_valid;
            t_first <= s1_first;
            t_last  <= s1_last;
            // Negating a zero magnitude yields zero, so -0 never appears
            t_term  <= s1_sign ? ('0 - mag) : mag;
`ifdef FP8_MAC_NAN_EN
            t_nan   <= s1_nan;
`endif
        end
    end

endmodule

// File: rtl/fp8_mac_pe.sv
// Pipelined E4M3 multiply-accumulate processing element.
// S1/S2 live in fp8_product_align; this module holds the saturating
// accumulator (S3) and the result register. Latency from an accepted
// last beat to out_valid is 4 cycles; one pair accepted per valid cycle.
// Optional feature macro: FP8_MAC_NAN_EN adds NaN detection and the nan port.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid, first, last         beat qualifiers
//   a_sign/a_exp/a_mant, b_*      decoded operands (mant[3] = hidden bit)
//   out_valid                     one-cycle pulse per completed run
//   acc_out                       signed run result, LSB weight 2^-18, held
//   ovf                           run saturated at least once, held
//   nan                           (FP8_MAC_NAN_EN only) run saw a NaN operand
module fp8_mac_pe
    import fp8_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             first,
    input  logic             last,
    input  logic             a_sign,
    input  logic [3:0]       a_exp,
    input  logic [3:0]       a_mant,
    input  logic             b_sign,
    input  logic [3:0]       b_exp,
    input  logic [3:0]       b_mant,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
`ifdef FP8_MAC_NAN_EN
    ,
    output logic             nan
`endif
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    fp8_dec_t         op_a;
    fp8_dec_t         op_b;
    logic             t_valid;
    logic             t_first;
    logic             t_last;
    logic [ACC_W-1:0] t_term;

    logic [ACC_W-1:0] acc;
    logic             ovf_sticky;
    logic             s3_last;
    logic [ACC_W:0]   sum_ext;
    logic             sat_hi;
    logic             sat_lo;
    logic [ACC_W-1:0] acc_sum;

`ifdef FP8_MAC_NAN_EN
    logic             t_nan;
    logic             nan_sticky;
`endif

    assign op_a = {a_sign, a_exp, a_mant};
    assign op_b = {b_sign, b_exp, b_mant};

    fp8_product_align #(
        .ACC_W (ACC_W)
    ) u_align (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .first    (first),
        .last     (last),
        .a        (op_a),
        .b        (op_b),
        .t_valid  (t_valid),
        .t_first  (t_first),
        .t_last   (t_last),
        .t_term   (t_term)
`ifdef FP8_MAC_NAN_EN
        ,
        .t_nan    (t_nan)
`endif
    );

    // One guard bit: overflow shows as disagreement of the top two bits
    always_comb begin
        sum_ext = {acc[ACC_W-1], acc} + {t_term[ACC_W-1], t_term};
        sat_hi  = ~sum_ext[ACC_W] &  sum_ext[ACC_W-1];
        sat_lo  =  sum_ext[ACC_W] & ~sum_ext[ACC_W-1];
        if (sat_hi) begin
            acc_sum = ACC_MAX;
        end else if (sat_lo) begin
            acc_sum = ACC_MIN;
        end else begin
            acc_sum = sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
            s3_last    <= 1'b0;
`ifdef FP8_MAC_NAN_EN
            nan_sticky <= 1'b0;
`endif
        end else begin
            s3_last <= t_valid & t_last;
            if (t_valid) begin
                if (t_first) begin
                    // A lone term always fits, so a load can never saturate
                    acc        <= t_term;
                    ovf_sticky <= 1'b0;
`ifdef FP8_MAC_NAN_EN
                    nan_sticky <= t_nan;
`endif
                end else begin
                    acc        <= acc_sum;
                    ovf_sticky <= ovf_sticky | sat_hi | sat_lo;
`ifdef FP8_MAC_NAN_EN
                    nan_sticky <= nan_sticky | t_nan;
`endif
                end
            end
        end
    end

    // Copies the accumulator one edge after the last beat landed in it, so a
    // new run's first beat can overwrite acc on the same edge safely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            acc_out   <= '0;
            ovf       <= 1'b0;
`ifdef FP8_MAC_NAN_EN
            nan       <= 1'b0;
`endif
        end else begin
            out_valid <= s3_last;
            if (s3_last) begin
                acc_out <= acc;
                ovf     <= ovf_sticky;
`ifdef FP8_MAC_NAN_EN
                nan     <= nan_sticky;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp8_mac_pe.sv
module tb_fp8_mac_pe;

    localparam int ACC_W = 40;
    localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

    typedef struct {
        longint acc;
        bit     ovf;
        bit     nan;
        int     cyc;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             first;
    logic             last;
    logic             a_sign;
    logic [3:0]       a_exp;
    logic [3:0]       a_mant;
    logic             b_sign;
    logic [3:0]       b_exp;
    logic [3:0]       b_mant;
    logic             out_valid;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
`ifdef FP8_MAC_NAN_EN
    logic             nan;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    res_t   exp_q[$];
    res_t   obs_q[$];
    longint m_acc = 0;
    bit     m_ovf = 0;
    bit     m_nan = 0;

    fp8_mac_pe #(
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .first     (first),
        .last      (last),
        .a_sign    (a_sign),
        .a_exp     (a_exp),
        .a_mant    (a_mant),
        .b_sign    (b_sign),
        .b_exp     (b_exp),
        .b_mant    (b_mant),
        .out_valid (out_valid),
        .acc_out   (acc_out),
        .ovf       (ovf)
`ifdef FP8_MAC_NAN_EN
        ,
        .nan       (nan)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Capture every result pulse; tasks compare against the model queue
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            res_t r;
            r.acc = longint'($signed(acc_out));
            r.ovf = ovf;
`ifdef FP8_MAC_NAN_EN
            r.nan = nan;
`else
            r.nan = 1'b0;
`endif
            r.cyc = cyc;
            obs_q.push_back(r);
        end
    end

    // Operand value in units of 2^-9: (m/8) * 2^(e_eff-7) = m * 2^(e_eff-1) * 2^-9,
    // so a product of two such values is directly in accumulator LSBs (2^-18).
    function automatic longint op_val(logic [3:0] e, logic [3:0] m);
        int ee;
        ee = (e == 4'd0) ? 1 : int'(e);
        return longint'(m) * (longint'(1) <<< (ee - 1));
    endfunction

    function automatic bit op_is_nan(logic [3:0] e, logic [3:0] m);
`ifdef FP8_MAC_NAN_EN
        return (e == 4'hF) && (m[2:0] == 3'b111);
`else
        return 1'b0;
`endif
    endfunction

    task automatic beat(bit f, bit l, bit as, logic [3:0] ae, logic [3:0] am,
                        bit bs, logic [3:0] be, logic [3:0] bm);
        longint t;
        bit     n;
        res_t   r;
        @(negedge clk);
        in_valid = 1'b1; first = f; last = l;
        a_sign = as; a_exp = ae; a_mant = am;
        b_sign = bs; b_exp = be; b_mant = bm;
        n = op_is_nan(ae, am) || op_is_nan(be, bm);
        t = n ? 0 : op_val(ae, am) * op_val(be, bm);
        if (as ^ bs) t = -t;
        if (f) begin
            m_acc = t; m_ovf = 1'b0; m_nan = n;
        end else begin
            m_acc = m_acc + t;
            m_nan = m_nan | n;
            if (m_acc > MAXV) begin m_acc = MAXV; m_ovf = 1'b1; end
            else if (m_acc < MINV) begin m_acc = MINV; m_ovf = 1'b1; end
        end
        if (l) begin
            r.acc = m_acc; r.ovf = m_ovf; r.nan = m_nan; r.cyc = cyc + 4;
            exp_q.push_back(r);
        end
    endtask

    task automatic bubble(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; first = 1'b0; last = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0 || acc_out !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b acc_out=%0d ovf=%b, required all 0", out_valid, acc_out, ovf);
        end
`ifdef FP8_MAC_NAN_EN
        n_checks++;
        if (nan !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nan: nan=%b, required 0", nan);
        end
`endif
    endtask

    task automatic test_unit_product();
        res_t o, e;
        beat(1, 1, 0, 4'd7, 4'd8, 0, 4'd7, 4'd8);
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL unit_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL unit_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_bubble_run();
        res_t o, e;
        beat(1, 0, 0, 4'd7, 4'd8, 0, 4'd7, 4'd8);
        bubble(1);
        beat(0, 1, 1, 4'd7, 4'd8, 0, 4'd6, 4'd8);
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bubble_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL bubble_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_denormal_zero();
        res_t o, e;
        beat(1, 1, 0, 4'd0, 4'd1, 0, 4'd0, 4'd1);
        beat(1, 1, 1, 4'd9, 4'd0, 0, 4'd7, 4'd8);
        beat(1, 1, 0, 4'd0, 4'd7, 1, 4'd3, 4'd12);
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL denorm_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL denorm_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        res_t o, e;
        int   nb;
        logic [3:0] m;
`ifdef FP8_MAC_NAN_EN
        nb = 12; m = 4'd14;
`else
        nb = 10; m = 4'd15;
`endif
        for (int i = 0; i < nb; i++) begin
            beat(i == 0, i == nb - 1, 0, 4'd15, m, 0, 4'd15, m);
        end
        beat(1, 1, 1, 4'd15, m, 0, 4'd15, m);
        for (int i = 0; i < nb; i++) begin
            beat(i == 0, i == nb - 1, 1, 4'd15, m, 0, 4'd15, m);
        end
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL sat_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL sat_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

`ifdef FP8_MAC_NAN_EN
    task automatic test_nan();
        res_t o, e;
        beat(1, 0, 0, 4'd7, 4'd8, 0, 4'd7, 4'd8);
        beat(0, 0, 0, 4'd15, 4'd15, 0, 4'd7, 4'd8);
        beat(0, 1, 0, 4'd7, 4'd8, 1, 4'd15, 4'd7);
        beat(1, 1, 0, 4'd7, 4'd8, 0, 4'd7, 4'd8);
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL nan_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL nan_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_back_to_back();
        res_t o, e;
        for (int i = 0; i < 6; i++) begin
            beat(1, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 4'($urandom_range(8, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 4'($urandom_range(8, 15)));
        end
        // last of one run followed immediately by first of the next
        beat(1, 0, 0, 4'd8, 4'd9, 0, 4'd5, 4'd10);
        beat(0, 1, 1, 4'd2, 4'd11, 0, 4'd12, 4'd13);
        beat(1, 1, 0, 4'd4, 4'd14, 1, 4'd6, 4'd9);
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL b2b_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        res_t o, e;
        int   len;
        logic [3:0] ea, eb, ma, mb;
        for (int r = 0; r < 25; r++) begin
            len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                ea = 4'($urandom_range(0, 15));
                eb = 4'($urandom_range(0, 15));
                ma = (ea == 4'd0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
                mb = (eb == 4'd0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
                if ($urandom_range(0, 9) == 0) ma = 4'd0;
                beat(k == 0, k == len - 1, 1'($urandom_range(0, 1)), ea, ma,
                     1'($urandom_range(0, 1)), eb, mb);
                if ($urandom_range(0, 3) == 0) bubble(int'($urandom_range(1, 2)));
            end
        end
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL rand_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_run_reset();
        res_t o, e;
        beat(1, 0, 0, 4'd9, 4'd12, 0, 4'd9, 4'd12);
        beat(0, 1, 0, 4'd9, 4'd12, 0, 4'd9, 4'd12);
        @(negedge clk);
        in_valid = 1'b0; first = 1'b0; last = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || acc_out !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: out_valid=%b acc_out=%0d ovf=%b, required all 0", out_valid, acc_out, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_stale: got %0d results after reset, required 0", obs_q.size());
        end
        obs_q.delete();
        beat(1, 1, 1, 4'd7, 4'd8, 0, 4'd8, 4'd10);
        bubble(1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL postreset_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if (o.acc !== e.acc || o.ovf !== e.ovf || o.nan !== e.nan || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL postreset_result: acc=%0d ovf=%0b nan=%0b cyc=%0d, required acc=%0d ovf=%0b nan=%0b cyc=%0d",
                         o.acc, o.ovf, o.nan, o.cyc, e.acc, e.ovf, e.nan, e.cyc);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; first = 1'b0; last = 1'b0;
        a_sign = 1'b0; a_exp = 4'd0; a_mant = 4'd0;
        b_sign = 1'b0; b_exp = 4'd0; b_mant = 4'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_unit_product();
        test_bubble_run();
        test_denormal_zero();
        test_saturation();
`ifdef FP8_MAC_NAN_EN
        test_nan();
`endif
        test_back_to_back();
        test_random();
        test_mid_run_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp8_mac_pe.md
# fp8_mac_pe

Pipelined E4M3 multiply-accumulate processing element that consumes two decoded FP8 operands per cycle (sign, 4-bit exponent, 4-bit mantissa with hidden bit already applied) from the FP8 decoder stage. It forms the exact product, aligns it to a fixed-point grid and accumulates it into a saturating two's-complement accumulator. It emits one result per dot-product run delimited by `first`/`last`. It sits directly downstream of the decoder in each systolic-array PE.

## Interface
Parameters:
- `ACC_W`, default 48: accumulator width in bits; legal range is 40 or more. LSB weight is 2^-18.

Ports:
- `clk`, input, 1: single clock; all state is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: an operand pair is present this cycle.
- `first`, input, 1: this pair starts a new run; the accumulator is loaded rather than added to.
- `last`, input, 1: this pair ends the run.
- `a_sign`, `b_sign`, input, 1 each: operand signs.
- `a_exp`, `b_exp`, input, 4 each: raw biased exponents.
- `a_mant`, `b_mant`, input, 4 each: mantissas; bit 3 is the hidden bit (0 for denormals).
- `out_valid`, output, 1: one-cycle pulse when a run result is available.
- `acc_out`, output, ACC_W: signed run result; held until the next result.
- `ovf`, output, 1: the run saturated at least once; held with `acc_out`.
- `nan`, output, 1: present only with `FP8_MAC_NAN_EN` (see Configuration).

## Operation
- Effective exponent `e_eff = (exp==0) ? 1 : exp`.
- Product magnitude `p = a_mant*b_mant` (8 bits, at most 225).
- Shift `s = e_eff_a + e_eff_b - 2` (5 bits, range 0..28).
- Term `t = p << s`, sign `a_sign^b_sign`, sign-extended to ACC_W and negated when the sign is 1. A zero mantissa gives `t = 0` regardless of sign.
- Stage S1 registers `p`, `s`, sign and control bits. S2 registers signed `t`. S3 is the accumulator.
- At S3 on a valid beat:
  - `first=1`: `acc <= t`, and the sticky flags are cleared and then updated from this beat.
  - `first=0`: `acc <= sat(acc + t)`.
- Saturation clamps to `2^(ACC_W-1)-1` or `-2^(ACC_W-1)` and sets the sticky overflow bit.
- A valid beat with `last=1` at S3 copies the post-update acc and flags to `acc_out`/`ovf`/`nan` on the next edge and pulses `out_valid`.
- Invalid beats are bubbles: no accumulator or flag change. Bubbles are allowed anywhere inside a run.
- `first` and `last` on the same beat produce a single-product result.
- A `first` beat that arrives while the previous run's `last` is still in flight is legal; stage order preserves both runs.
- A valid beat with neither `first` nor `last`, after a completed run, keeps accumulating onto the old acc. This is legal but undefined by contract.
- No backpressure: one pair is accepted every cycle that `in_valid=1`.

## Timing
- A pair accepted in cycle N reaches S1 at edge N+1, S2 at N+2 and the accumulator at N+3.
- If that pair has `last=1`, `out_valid` is high and `acc_out` is valid during cycle N+4. Latency is 4.
- Throughput is 1 pair/cycle. Back-to-back runs can produce `out_valid` on consecutive cycles.
- Reset values: all pipeline valids, `acc`, `acc_out`, `out_valid`, `ovf`, `nan` and the sticky flags are 0.
- Reset mid-run discards all in-flight beats; the first post-reset beat must carry `first=1`.

## Configuration
- `FP8_MAC_NAN_EN` defined:
  - An operand with `exp==4'hF` and `mant[2:0]==3'b111` (E4M3 NaN) sets the sticky NaN bit; its term is forced to 0.
  - The `nan` port exists and is reported with each result.
- Not defined: there is no `nan` port, and that encoding is treated numerically as 480.0 (`mant=15`, `exp=15`).

## Structure
- Shared package `fp8_pkg`:
  - `E4M3_BIAS=7`, `ACC_LSB_EXP=-18`, `SHIFT_W=5`, `PROD_W=8`.
  - NaN exponent and mantissa constants.
  - A typedef for the decoded-operand bundle {sign, exp[3:0], mant[3:0]}.
- One sub-module, `fp8_product_align`, holds S1 and S2 (multiply, exponent add, shift, signed term). The top holds S3, the saturation logic and the output register.

## Test plan
- 1.0×1.0 (`exp=7`, `mant=8`), `first=last=1` -> `out_valid` 4 cycles later, `acc_out=262144`, `ovf=0`.
- Run 1.0×1.0 then −1.0×0.5 (`a_sign=1`; 0.5 = `exp 6`, `mant 8`) with a bubble between them -> `acc_out=131072`.
- Minimum denormal 001×001 (`exp=0`, `mant=1`) -> `acc_out=1`. Any zero mantissa with sign 1 -> `acc_out=0`.
- `ACC_W=40`, ten products of 480×480 (`exp=15`, `mant=15`, macro off) -> term 225<<28 each, tenth saturates, `acc_out=2^39-1`, `ovf=1`. A following single-product run -> `ovf=0`.
- Macro on: a NaN operand mid-run -> `nan=1` with the result, term contributes 0. The next run without NaN -> `nan=0`.
- Back-to-back runs of 1 pair each on consecutive cycles -> `out_valid` on consecutive cycles with the correct values. Assert `rst_n=0` mid-run -> all outputs are 0 and no stale `out_valid`.
